// File: rtl/gate_sequencer_if.sv
// Control bundle between the gate sequencer and the counter/display chain.
// master = sequencer side, slave = counter, display and operator-control side.
interface gate_sequencer_if;
    logic       run;
    logic [1:0] range_sel;
    logic       auto_en;
    logic       ovf;
    logic       msd_zero;
    logic       cnt_clr;
    logic       gate;
    logic       latch;
    logic [1:0] range;
    logic [1:0] dp_pos;
    logic       overrange;
    logic       busy;

    modport master (
        input  run, range_sel, auto_en, ovf, msd_zero,
        output cnt_clr, gate, latch, range, dp_pos, overrange, busy
    );

    modport slave (
        output run, range_sel, auto_en, ovf, msd_zero,
        input  cnt_clr, gate, latch, range, dp_pos, overrange, busy
    );
endinterface

// File: rtl/gate_sequencer.sv
// Measurement sequencer for the frequency counter: clear -> gate -> drain -> latch -> hold.
// Define AUTORANGE_EN to compile in gate-time autoranging (auto_en selects it at run time).
module gate_sequencer #(
    parameter int GATE_CYC = 50_000_000,
    parameter int HOLD_CYC = 25_000_000,
    parameter int CW       = 26
) (
    input logic              clk,
    input logic              reset_n,
    gate_sequencer_if.master bus
);

    typedef enum logic [2:0] {IDLE, CLR, GATE, DRAIN, LATCH, HOLD} state_t;

    localparam logic [CW-1:0] GATE_LD0 = CW'(GATE_CYC - 1);
    localparam logic [CW-1:0] GATE_LD1 = CW'(GATE_CYC / 10 - 1);
    localparam logic [CW-1:0] GATE_LD2 = CW'(GATE_CYC / 100 - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    function automatic logic [1:0] clamp_range(input logic [1:0] sel);
        return (sel == 2'd3) ? 2'd2 : sel;
    endfunction

    function automatic logic [CW-1:0] gate_load(input logic [1:0] r);
        case (r)
            2'd0:    return GATE_LD0;
            2'd1:    return GATE_LD1;
            default: return GATE_LD2;
        endcase
    endfunction

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    range_q;
    logic [1:0]    nxt_range;
    logic          ovf_seen;
    logic          upshift_q;
    logic          cnt_clr_q, gate_q, latch_q, overrange_q, busy_q;
    logic          ovf_p0, ovf_p1, ovf_p2;
    logic          ovf_hit;
    logic          auto_on;
    logic [1:0]    load_range;
    logic          dec_latch, dec_over, dec_up;
    logic [1:0]    dec_range;

    // ovf is an asynchronous level: two synchroniser flops, a third for rising-edge detect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_p0 <= 1'b0;
            ovf_p1 <= 1'b0;
            ovf_p2 <= 1'b0;
        end else begin
            ovf_p0 <= bus.ovf;
            ovf_p1 <= ovf_p0;
            ovf_p2 <= ovf_p1;
        end
    end

    assign ovf_hit = ovf_seen | (ovf_p1 & ~ovf_p2 & ((state == GATE) | (state == DRAIN)));

`ifdef AUTORANGE_EN
    assign auto_on = bus.auto_en;

    always_comb begin
        dec_latch = 1'b1;
        dec_over  = ovf_hit;
        dec_up    = 1'b0;
        dec_range = range_q;
        if (auto_on) begin
            if (ovf_hit && range_q != 2'd2) begin
                dec_latch = 1'b0;
                dec_over  = overrange_q;
                dec_up    = 1'b1;
                dec_range = range_q + 2'd1;
            end else if (!ovf_hit && bus.msd_zero && range_q != 2'd0) begin
                dec_range = range_q - 2'd1;
            end
        end
    end
`else
    logic unused_inputs;

    assign unused_inputs = bus.auto_en ^ bus.msd_zero;
    assign auto_on       = 1'b0;
    assign dec_latch     = 1'b1;
    assign dec_over      = ovf_hit;
    assign dec_up        = 1'b0;
    assign dec_range     = range_q;
`endif

    assign load_range = auto_on ? nxt_range : clamp_range(bus.range_sel);

    // Outputs are registered from the state being entered, so each strobe lines up with its state.
    // The latch decision is therefore taken on the DRAIN->LATCH edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            range_q     <= 2'd0;
            nxt_range   <= 2'd0;
            ovf_seen    <= 1'b0;
            upshift_q   <= 1'b0;
            cnt_clr_q   <= 1'b0;
            gate_q      <= 1'b0;
            latch_q     <= 1'b0;
            overrange_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cnt_clr_q <= 1'b0;
            latch_q   <= 1'b0;
            ovf_seen  <= ovf_hit;
            case (state)
                IDLE: begin
                    if (bus.run) begin
                        state     <= CLR;
                        cnt_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                        range_q   <= load_range;
                    end
                end
                CLR: begin
                    state    <= GATE;
                    gate_q   <= 1'b1;
                    cnt      <= gate_load(range_q);
                    ovf_seen <= 1'b0;
                end
                GATE: begin
                    if (cnt == '0) begin
                        state  <= DRAIN;
                        gate_q <= 1'b0;
                        cnt    <= ONE;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                DRAIN: begin
                    if (cnt == '0) begin
                        state     <= LATCH;
                        latch_q   <= dec_latch;
                        upshift_q <= dec_up;
                        nxt_range <= dec_range;
                        if (dec_latch) overrange_q <= dec_over;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                LATCH: begin
                    upshift_q <= 1'b0;
                    if (upshift_q) begin
                        state     <= CLR;
                        cnt_clr_q <= 1'b1;
                        range_q   <= load_range;
                    end else begin
                        state <= HOLD;
                        cnt   <= HOLD_LD;
                    end
                end
                HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - ONE;
                    end else if (bus.run) begin
                        state     <= CLR;
                        cnt_clr_q <= 1'b1;
                        range_q   <= load_range;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    gate_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cnt_clr   = cnt_clr_q;
    assign bus.gate      = gate_q;
    assign bus.latch     = latch_q;
    assign bus.range     = range_q;
    assign bus.dp_pos    = range_q;
    assign bus.overrange = overrange_q;
    assign bus.busy      = busy_q;

endmodule
